multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// multi_timer: N_CH independent millisecond timers (up/down, one-shot/periodic) sharing one prescaler.
// Latency: a load, a step, expire and done all appear one cycle after the edge that causes them; tick is registered.
// Backpressure: none; strobes are accepted every cycle, and a tick seen while a channel is gated is dropped.
// Ports: clk, reset (synchronous, active-high); per-channel ch_load, ch_up, ch_periodic, ch_enable, ch_clear_done;
//        shared load_value; timer_value (channel i at [i*W +: W]); done (sticky); expire (pulse); tick (ms pulse).
module multi_timer #(
   parameter  int N_CH        = 4,
   parameter  int MAX_MS      = 2047,
   parameter  int CLKS_PER_MS = 50000,
   localparam int W           = $clog2(MAX_MS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   ch_load,
   input  logic [N_CH-1:0]   ch_up,
   input  logic [N_CH-1:0]   ch_periodic,
   input  logic [N_CH-1:0]   ch_enable,
   input  logic [W-1:0]      load_value,
   input  logic [N_CH-1:0]   ch_clear_done,
   output logic [N_CH*W-1:0] timer_value,
   output logic [N_CH-1:0]   done,
   output logic [N_CH-1:0]   expire,
   output logic              tick
);

   localparam int            PW       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);
   localparam logic [W-1:0]  MAX_W    = W'(MAX_MS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   // ---------------- shared prescaler ----------------
   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q;

   always_comb begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
   end

   // tick_q is registered from the next count so it is high exactly while pre_q sits at its last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= (pre_d == PRE_LAST);
      end
   end

   // ---------------- per-channel state ----------------
   state_t          state_q  [N_CH];
   state_t          state_d  [N_CH];
   logic [W-1:0]    val_q    [N_CH];
   logic [W-1:0]    val_d    [N_CH];
   logic [W-1:0]    preset_q [N_CH];
   logic [W-1:0]    preset_d [N_CH];
   logic [N_CH-1:0] up_q, up_d;
   logic [N_CH-1:0] per_q, per_d;
   logic [N_CH-1:0] done_q, done_d;
   logic [N_CH-1:0] exp_q, exp_d;
   logic [W-1:0]    preset_in;

   // Compare in int so the clamp stays lint-quiet when MAX_MS fills the whole port range.
   always_comb begin
      preset_in = (int'(load_value) > MAX_MS) ? MAX_W : load_value;
   end

   always_comb begin
      logic         hit;
      logic [W-1:0] term;
      logic [W-1:0] start;
      logic [W-1:0] step;
      hit    = 1'b0;
      term   = '0;
      start  = '0;
      step   = '0;
      up_d   = up_q;
      per_d  = per_q;
      done_d = done_q;
      exp_d  = '0;
      for (int i = 0; i < N_CH; i++) begin
         state_d[i]  = state_q[i];
         val_d[i]    = val_q[i];
         preset_d[i] = preset_q[i];
         hit   = 1'b0;
         term  = up_q[i] ? preset_q[i] : '0;
         start = up_q[i] ? '0 : preset_q[i];
         step  = up_q[i] ? val_q[i] + 1'b1 : val_q[i] - 1'b1;

         if (ch_load[i]) begin
            // A load restarts the channel from any state and leaves done untouched.
            preset_d[i] = preset_in;
            up_d[i]     = ch_up[i];
            per_d[i]    = ch_periodic[i];
            if (preset_in == '0) begin
               // Zero-length timer: expires immediately, never auto-reloads.
               val_d[i]   = '0;
               state_d[i] = EXPIRED;
               hit        = 1'b1;
            end else begin
               val_d[i]   = ch_up[i] ? '0 : preset_in;
               state_d[i] = RUN;
            end
         end else begin
            case (state_q[i])
               RUN: begin
                  if (tick_q && ch_enable[i]) begin
                     if (step == term) begin
                        hit = 1'b1;
                        // Periodic reload skips the terminal value so the period is exactly P ticks.
                        if (per_q[i]) begin
                           val_d[i] = start;
                        end else begin
                           val_d[i]   = term;
                           state_d[i] = EXPIRED;
                        end
                     end else begin
                        val_d[i] = step;
                     end
                  end
               end
               default: begin
                  // IDLE and EXPIRED hold their value and ignore ticks.
               end
            endcase
         end

         // Expiry beats a same-cycle clear.
         if (hit) begin
            done_d[i] = 1'b1;
         end else if (ch_clear_done[i]) begin
            done_d[i] = 1'b0;
         end
         exp_d[i] = hit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i]  <= IDLE;
            val_q[i]    <= '0;
            preset_q[i] <= '0;
         end
         up_q   <= '0;
         per_q  <= '0;
         done_q <= '0;
         exp_q  <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i]  <= state_d[i];
            val_q[i]    <= val_d[i];
            preset_q[i] <= preset_d[i];
         end
         up_q   <= up_d;
         per_q  <= per_d;
         done_q <= done_d;
         exp_q  <= exp_d;
      end
   end

   always_comb begin
      timer_value = '0;
      for (int i = 0; i < N_CH; i++) begin
         timer_value[i*W +: W] = val_q[i];
      end
   end

   assign done   = done_q;
   assign expire = exp_q;
   assign tick   = tick_q;

endmodule
